// File: rtl/fork_join_dispatcher.sv
// fork_join_dispatcher
//   Forks one data word per channel to NUM_CH workers over valid/ready links,
//   joins once every channel has handshaken, then waits for one response.
//   A per-phase watchdog aborts a stalled fork or a missing response into a
//   sticky DEADLOCK state that is left only through clear_i.
//
// Ports
//   clk_i, rst_i            clock (rising edge), asynchronous active-high reset
//   start_i, start_data_i   launch a transaction (IDLE only); word i at [i*DATA_W +: DATA_W]
//   busy_o                  high in every state except IDLE
//   ch_valid_o/ch_data_o    per-channel send valid and latched words
//   ch_ready_i              per-channel worker ready
//   rsp_valid_i/rsp_data_i  response handshake and word; rsp_ready_o accepts it
//   done_o                  one-cycle pulse after the response is accepted
//   result_o                last accepted response word
//   deadlock_o              sticky watchdog flag
//   deadlock_phase_o        0 = fork stalled, 1 = response missing
//   stall_mask_o            channels still pending when the fork stalled
//   clear_i                 leave DEADLOCK
module fork_join_dispatcher #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [NUM_CH*DATA_W-1:0]   start_data_i,
    output logic                       busy_o,
    output logic [NUM_CH-1:0]          ch_valid_o,
    output logic [NUM_CH*DATA_W-1:0]   ch_data_o,
    input  logic [NUM_CH-1:0]          ch_ready_i,
    input  logic                       rsp_valid_i,
    input  logic [DATA_W-1:0]          rsp_data_i,
    output logic                       rsp_ready_o,
    output logic                       done_o,
    output logic [DATA_W-1:0]          result_o,
    output logic                       deadlock_o,
    output logic                       deadlock_phase_o,
    output logic [NUM_CH-1:0]          stall_mask_o,
    input  logic                       clear_i
);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StFork     = 2'd1;
    localparam logic [1:0] StWaitRsp  = 2'd2;
    localparam logic [1:0] StDeadlock = 2'd3;

    // TIMEOUT = 0 disables the watchdog; keep a 1-bit counter so widths stay legal.
    localparam bit          WdEn   = (TIMEOUT > 0);
    localparam int unsigned CntW   = WdEn ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(WdEn ? TIMEOUT - 1 : 0);

    logic [1:0]               state_q, state_d;
    logic [NUM_CH-1:0]        pending_q, pending_d;
    logic [NUM_CH*DATA_W-1:0] ch_data_q, ch_data_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic                     done_q, done_d;
    logic [DATA_W-1:0]        result_q, result_d;
    logic                     deadlock_q, deadlock_d;
    logic                     phase_q, phase_d;
    logic [NUM_CH-1:0]        mask_q, mask_d;

    logic [NUM_CH-1:0]        fork_hs;
    logic [NUM_CH-1:0]        pending_left;
    logic                     progress;
    logic                     wd_expire;

    assign fork_hs      = pending_q & ch_ready_i;
    assign pending_left = pending_q & ~ch_ready_i;

    // Any handshake in the current phase counts as progress and resets the watchdog.
    assign progress  = ((state_q == StFork) && (|fork_hs)) ||
                       ((state_q == StWaitRsp) && rsp_valid_i);
    // Counter at TIMEOUT-1 means this is the TIMEOUT-th stall cycle.
    assign wd_expire = WdEn && (cnt_q == CntMax) && !progress;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        ch_data_d  = ch_data_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        result_d   = result_q;
        deadlock_d = deadlock_q;
        phase_d    = phase_q;
        mask_d     = mask_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    ch_data_d = start_data_i;
                    pending_d = '1;
                    cnt_d     = '0;
                    state_d   = StFork;
                end
            end
            StFork: begin
                if (pending_left == '0) begin
                    pending_d = '0;
                    cnt_d     = '0;
                    state_d   = StWaitRsp;
                end else if (wd_expire) begin
                    mask_d     = pending_q;
                    phase_d    = 1'b0;
                    deadlock_d = 1'b1;
                    pending_d  = '0;
                    state_d    = StDeadlock;
                end else begin
                    pending_d = pending_left;
                    if (|fork_hs || !WdEn) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StWaitRsp: begin
                if (rsp_valid_i) begin
                    result_d = rsp_data_i;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end else if (wd_expire) begin
                    mask_d     = '0;
                    phase_d    = 1'b1;
                    deadlock_d = 1'b1;
                    state_d    = StDeadlock;
                end else if (WdEn) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDeadlock: begin
                // clear wins over start; a simultaneous start is dropped.
                if (clear_i) begin
                    deadlock_d = 1'b0;
                    phase_d    = 1'b0;
                    mask_d     = '0;
                    cnt_d      = '0;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            pending_q  <= '0;
            ch_data_q  <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            result_q   <= '0;
            deadlock_q <= 1'b0;
            phase_q    <= 1'b0;
            mask_q     <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            ch_data_q  <= ch_data_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            result_q   <= result_d;
            deadlock_q <= deadlock_d;
            phase_q    <= phase_d;
            mask_q     <= mask_d;
        end
    end

    assign busy_o           = (state_q != StIdle);
    assign ch_valid_o       = (state_q == StFork) ? pending_q : '0;
    assign ch_data_o        = ch_data_q;
    assign rsp_ready_o      = (state_q == StWaitRsp);
    assign done_o           = done_q;
    assign result_o         = result_q;
    assign deadlock_o       = deadlock_q;
    assign deadlock_phase_o = phase_q;
    assign stall_mask_o     = mask_q;

endmodule
